// File: rtl/radix_bist_pkg.sv
// Shared definitions for the BIST signature checker.
//   state_e   : checker FSM states
//   SIG_W     : signature width
//   MISR_POLY : feedback taps of the 16-bit MISR (CRC-CCITT polynomial)
//   MISR_SEED : signature value loaded at the start of every run
package radix_bist_pkg;

  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] MISR_SEED = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register.
//   clk       : clock
//   reset_n   : async active-low reset, signature -> MISR_SEED
//   clear     : synchronous load of MISR_SEED (takes priority over enable)
//   enable    : compact result into the signature this cycle
//   result    : data word to compact
//   signature : current register contents
module misr16
  import radix_bist_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [SIG_W-1:0] result,
  output logic [SIG_W-1:0] signature
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_next;

  // Shift left, fold the outgoing MSB back through the polynomial, then mix in data.
  assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                  ^ result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= MISR_SEED;
    end else if (clear) begin
      sig_q <= MISR_SEED;
    end else if (enable) begin
      sig_q <= sig_next;
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/radix_bist_sig_checker.sv
// Compacts N_PATTERNS multiplier results into a MISR signature and compares
// the final value against GOLDEN_SIG.
//   clk       : clock
//   reset_n   : async active-low reset
//   start     : begin a new run (honoured in IDLE and DONE only)
//   ready     : multiplier ready; each 0->1 transition delivers one result
//   result    : signed multiplier product, valid while ready=1
//   busy      : run in progress
//   done      : run finished, signature frozen
//   pass      : done and signature matches GOLDEN_SIG
//   signature : current MISR contents
//   count     : results captured in the current run
//
// state | meaning
// IDLE  | waiting for start after reset; captures ignored
// RUN   | compacting one result per ready rise until N_PATTERNS captured
// DONE  | signature/count frozen, pass valid; start begins a fresh run
module radix_bist_sig_checker
  import radix_bist_pkg::*;
#(
  parameter int               N_PATTERNS = 64,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             ready,
  input  logic [SIG_W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [7:0]       count
);

  localparam logic [7:0] LAST_IDX = 8'(N_PATTERNS - 1);

  state_e     state_q, state_d;
  logic       ready_q;
  logic       capture;
  logic       start_accept;
  logic       run_capture;
  logic [7:0] count_q;

  // One capture per ready rise, however long ready stays high.
  assign capture = ready & ~ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready;
      if (start_accept) begin
        count_q <= '0;
      end else if (run_capture) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  // A start in IDLE/DONE wins over a simultaneous capture: run_capture is
  // only ever asserted in RUN, where start is ignored.
  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    run_capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (capture) begin
          run_capture = 1'b1;
          if (count_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  misr16 u_misr (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start_accept),
    .enable    (run_capture),
    .result    (result),
    .signature (signature)
  );

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign pass  = done && (signature == GOLDEN_SIG);
  assign count = count_q;

endmodule

// File: doc/radix_bist_sig_checker.md
RADIX_BIST_SIG_CHECKER -- requirements
Module: radix_bist_sig_checker

Interface
REQ-001 The block SHALL have parameter N_PATTERNS, default 64, giving the number of results compacted per run (legal range 1..255).
REQ-002 The block SHALL have parameter GOLDEN_SIG, default 16'h0000, giving the expected final signature.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: requests a new compaction run.
REQ-006 Port ready, input, 1 bit: the multiplier's ready; a new result is signalled by a 0->1 transition.
REQ-007 Port result, input, 16 bits: the signed multiplier product, valid whenever ready=1.
REQ-008 Port busy, output, 1 bit: high while in RUN.
REQ-009 Port done, output, 1 bit: high while in DONE.
REQ-010 Port pass, output, 1 bit: high only in DONE when signature equals GOLDEN_SIG.
REQ-011 Port signature, output, 16 bits: the current MISR contents.
REQ-012 Port count, output, 8 bits: the number of results captured in the current run.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 A registered copy ready_q SHALL be kept; capture SHALL be ready & ~ready_q, so ready held high for many cycles gives exactly one capture.
REQ-015 IDLE: start=1 SHALL clear signature to SEED (16'h0000), clear count to 0, and enter RUN on the next edge.
REQ-016 RUN: on capture, signature SHALL become {sig[14:0],1'b0} ^ (sig[15] ? POLY : 0) ^ result, with POLY = 16'h1021, and count SHALL increment by 1.
REQ-017 RUN: a capture with count = N_PATTERNS-1 SHALL enter DONE, so done is asserted in the cycle after the final capture edge.
REQ-018 DONE: signature and count SHALL hold, and pass SHALL equal (signature == GOLDEN_SIG), combinational from the registered signature.
REQ-019 DONE: start=1 SHALL clear signature and count and re-enter RUN.
REQ-020 start SHALL be ignored in RUN.
REQ-021 Captures SHALL be ignored in IDLE and DONE.
REQ-022 If start and capture occur in the same cycle in IDLE or DONE, start SHALL win and the capture SHALL be discarded.
REQ-023 count SHALL never wrap, because RUN exits at N_PATTERNS.
REQ-024 pass SHALL be 0 in IDLE and RUN.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state=IDLE, signature=16'h0000, count=0, ready_q=0, busy=0, done=0 and pass=0, in any state including mid-RUN.
REQ-026 After reset release, the block SHALL remain in IDLE until start=1 is sampled.

Structure
REQ-027 Package radix_bist_pkg SHALL hold the state enum (IDLE/RUN/DONE), SIG_W=16, MISR_POLY=16'h1021 and MISR_SEED=16'h0000.
REQ-028 Sub-module misr16 SHALL hold the signature register and update logic, with inputs clear and enable (enable = capture in RUN) and data input result.
REQ-029 The FSM, edge detector and counter SHALL live in radix_bist_sig_checker.

Verification
REQ-030 N_PATTERNS=1, GOLDEN_SIG=16'hFFF4, reset, start, then one ready rise with result=16'hFFF4 (-6*2) -> done=1 one cycle later, signature=16'hFFF4, count=1, pass=1.
REQ-031 Same configuration with result=16'h0004 -> done=1, signature=16'h0004, pass=0.
REQ-032 N_PATTERNS=2, two ready rises each with result=16'h0001 -> signature 16'h0001 after the first, then 16'h0003 after the second, with done=1.
REQ-033 ready held high for 5 cycles in RUN with N_PATTERNS=4 -> count=1, signature updated exactly once, busy stays 1.
REQ-034 reset_n pulsed low after one capture in RUN -> immediately busy=0, signature=16'h0000, count=0, done=0; a ready rise afterwards while in IDLE -> no change.
REQ-035 start held high throughout RUN -> no restart (count keeps rising); start in DONE -> signature=16'h0000, count=0, busy=1 on the next cycle.
